// File: rtl/vpe_vadd_relu_wb.sv
// vpe_vadd_relu_wb: SIMD writeback stage with saturating RF add, ReLU, 32-entry vector RF and read port
module vpe_vadd_relu_wb #(
  parameter int LANE_W = 16,
  parameter int NUM_LANE = 16,
  parameter int RF_DEPTH = 32,
  localparam int DATA_W = LANE_W * NUM_LANE,
  localparam int IDX_W = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_v,
  input  logic              i_en_vadd,
  input  logic              i_en_relu,
  input  logic [IDX_W-1:0]  i_rf_idx,
  input  logic [1:0]        i_rf_mux,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic              i_sat_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_v,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_v,
  output logic [NUM_LANE-1:0] o_sat,
  output logic              o_busy
);
  logic                s1_v_q, s1_vadd_q, s1_relu_q;
  logic [DATA_W-1:0]   s1_data_q;
  logic [IDX_W-1:0]    s1_idx_q;
  logic [1:0]          s1_mux_q;
  logic [DATA_W-1:0]   rf_q [RF_DEPTH];
  logic [DATA_W-1:0]   rf_op, res, wb_data, rd_data_d, o_data_q, o_rd_data_q;
  logic [NUM_LANE-1:0] hit, sat_hit, sat_d, o_sat_q;
  logic                wb_we, emit, o_data_v_q, o_rd_v_q;
  assign rf_op = rf_q[s1_idx_q];
  genvar k;
  for (k = 0; k < NUM_LANE; k++) begin : g_lane
    logic [LANE_W-1:0] a, b, s;
    logic [LANE_W:0]   sum;
    logic              ovf;
    assign a = s1_data_q[k*LANE_W +: LANE_W];
    assign b = rf_op[k*LANE_W +: LANE_W];
    assign sum = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    assign ovf = s1_vadd_q && (sum[LANE_W] != sum[LANE_W-1]);
    assign s = !s1_vadd_q ? a : ovf ? {sum[LANE_W], {(LANE_W-1){~sum[LANE_W]}}} : sum[LANE_W-1:0];
    assign res[k*LANE_W +: LANE_W] = (s1_relu_q && s[LANE_W-1]) ? '0 : s;
    assign hit[k] = ovf;
  end
  // writeback decode: mode 11 clears the entry and suppresses saturation reporting
  always_comb begin
    wb_we = s1_v_q && s1_mux_q != 2'b10;
    emit = s1_v_q && (s1_mux_q == 2'b01 || s1_mux_q == 2'b10);
    wb_data = s1_mux_q == 2'b11 ? '0 : res;
    sat_hit = (s1_v_q && s1_mux_q != 2'b11) ? hit : '0;
    sat_d = (i_sat_clr ? '0 : o_sat_q) | sat_hit;
    rd_data_d = (wb_we && s1_idx_q == i_rd_idx) ? wb_data : rf_q[i_rd_idx];
  end
  // S1 capture of the incoming op and its sideband
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_data_q <= '0;
      s1_vadd_q <= 1'b0;
      s1_relu_q <= 1'b0;
      s1_idx_q <= '0;
      s1_mux_q <= '0;
    end else begin
      s1_v_q <= i_data_v;
      if (i_data_v) begin
        s1_data_q <= i_data;
        s1_vadd_q <= i_en_vadd;
        s1_relu_q <= i_en_relu;
        s1_idx_q <= i_rf_idx;
        s1_mux_q <= i_rf_mux;
      end
    end
  end
  // register file write from S2
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[s1_idx_q] <= wb_data;
    end
  end
  // emitted result, write-first read port and sticky saturation flags
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data_q <= '0;
      o_data_v_q <= 1'b0;
      o_rd_data_q <= '0;
      o_rd_v_q <= 1'b0;
      o_sat_q <= '0;
    end else begin
      o_data_v_q <= emit;
      if (emit) o_data_q <= res;
      o_rd_v_q <= i_rd_en;
      if (i_rd_en) o_rd_data_q <= rd_data_d;
      o_sat_q <= sat_d;
    end
  end
  assign o_data = o_data_q;
  assign o_data_v = o_data_v_q;
  assign o_rd_data = o_rd_data_q;
  assign o_rd_v = o_rd_v_q;
  assign o_sat = o_sat_q;
  assign o_busy = s1_v_q;
endmodule

// File: tb/tb_vpe_vadd_relu_wb.sv
// tb_vpe_vadd_relu_wb: directed table plus randomized model check of the writeback stage
module tb_vpe_vadd_relu_wb;
  logic         clk = 1'b0, rst = 1'b1;
  logic [255:0] i_data = '0;
  logic         i_data_v = 1'b0, i_en_vadd = 1'b0, i_en_relu = 1'b0;
  logic [4:0]   i_rf_idx = '0, i_rd_idx = '0;
  logic [1:0]   i_rf_mux = '0;
  logic         i_rd_en = 1'b0, i_sat_clr = 1'b0;
  logic [255:0] o_data, o_rd_data;
  logic         o_data_v, o_rd_v, o_busy;
  logic [15:0]  o_sat;
  int errs = 0, checks = 0;

  vpe_vadd_relu_wb dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_data_v(i_data_v), .i_en_vadd(i_en_vadd),
    .i_en_relu(i_en_relu), .i_rf_idx(i_rf_idx), .i_rf_mux(i_rf_mux), .i_rd_en(i_rd_en),
    .i_rd_idx(i_rd_idx), .i_sat_clr(i_sat_clr), .o_data(o_data), .o_data_v(o_data_v),
    .o_rd_data(o_rd_data), .o_rd_v(o_rd_v), .o_sat(o_sat), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, dv, va, rl;
    logic [4:0] idx;
    logic [1:0] mux;
    logic [15:0] d;
    logic rd;
    logic [4:0] ridx;
    logic clr, edv;
    logic [15:0] edl;
    logic erv;
    logic [15:0] erl, esat;
    logic ebusy;
  } vec_t;

  localparam int NV = 28;
  vec_t tv [NV];

  function automatic vec_t mk(int r, int dv, int va, int rl, int idx, int mux, int d, int rd, int ridx,
                              int clr, int edv, int edl, int erv, int erl, int esat, int ebusy);
    vec_t v;
    v.rst = 1'(r); v.dv = 1'(dv); v.va = 1'(va); v.rl = 1'(rl);
    v.idx = 5'(idx); v.mux = 2'(mux); v.d = 16'(d); v.rd = 1'(rd); v.ridx = 5'(ridx);
    v.clr = 1'(clr); v.edv = 1'(edv); v.edl = 16'(edl); v.erv = 1'(erv); v.erl = 16'(erl);
    v.esat = 16'(esat); v.ebusy = 1'(ebusy);
    return v;
  endfunction

  // reference model: spec-level state updated once per clock edge
  logic [255:0] rf_m [32];
  logic         p_v = 1'b0, p_va = 1'b0, p_rl = 1'b0;
  logic [4:0]   p_idx = '0;
  logic [1:0]   p_mux = '0;
  logic [255:0] p_data = '0, m_data = '0, m_rd = '0;
  logic         m_dv = 1'b0, m_rv = 1'b0;
  logic [15:0]  m_sat = '0;

  task automatic model_edge();
    logic [255:0] r;
    logic [15:0] h;
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_m[i] = '0;
      p_v = 1'b0; m_data = '0; m_rd = '0; m_dv = 1'b0; m_rv = 1'b0; m_sat = '0;
    end else begin
      m_dv = 1'b0;
      h = '0;
      r = '0;
      if (p_v) begin
        for (int k = 0; k < 16; k++) begin
          int a, b, s;
          a = int'($signed(p_data[k*16 +: 16]));
          b = int'($signed(rf_m[p_idx][k*16 +: 16]));
          s = p_va ? a + b : a;
          if (s > 32767) begin s = 32767; h[k] = 1'b1; end
          if (s < -32768) begin s = -32768; h[k] = 1'b1; end
          if (p_rl && s < 0) s = 0;
          r[k*16 +: 16] = s[15:0];
        end
        case (p_mux)
          2'b00: rf_m[p_idx] = r;
          2'b01: begin rf_m[p_idx] = r; m_data = r; m_dv = 1'b1; end
          2'b10: begin m_data = r; m_dv = 1'b1; end
          default: begin rf_m[p_idx] = '0; h = '0; end
        endcase
      end
      m_sat = (i_sat_clr ? 16'h0 : m_sat) | h;
      m_rv = i_rd_en;
      if (i_rd_en) m_rd = rf_m[i_rd_idx];
      p_v = i_data_v;
      if (i_data_v) begin
        p_data = i_data; p_va = i_en_vadd; p_rl = i_en_relu; p_idx = i_rf_idx; p_mux = i_rf_mux;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk(string n, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int k = 0; k < 16; k++) begin
      logic [15:0] x;
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v[k*16 +: 16] = x;
        1: v[k*16 +: 16] = {8'h7F, x[7:0]};
        2: v[k*16 +: 16] = {8'h80, x[7:0]};
        default: v[k*16 +: 16] = {{12{x[3]}}, x[3:0]};
      endcase
    end
    return v;
  endfunction

  task automatic chk_model(string t);
    chk({t, " o_data_v"}, 256'(o_data_v), 256'(m_dv));
    chk({t, " o_data"}, o_data, m_data);
    chk({t, " o_rd_v"}, 256'(o_rd_v), 256'(m_rv));
    chk({t, " o_rd_data"}, o_rd_data, m_rd);
    chk({t, " o_sat"}, 256'(o_sat), 256'(m_sat));
    chk({t, " o_busy"}, 256'(o_busy), 256'(p_v));
  endtask

  initial begin
    tv[0]  = mk(1,0,0,0, 0,0,16'h0000,0,0,0,  0,16'h0000,0,16'h0000,16'h0000,0);
    tv[1]  = mk(1,1,0,0, 3,1,16'h0005,1,7,1,  0,16'h0000,0,16'h0000,16'h0000,0);
    tv[2]  = mk(0,0,0,0, 0,0,16'h0000,1,7,0,  0,16'h0000,1,16'h0000,16'h0000,0);
    tv[3]  = mk(0,1,0,0, 3,1,16'h0005,0,0,0,  0,16'h0000,0,16'h0000,16'h0000,1);
    tv[4]  = mk(0,0,0,0, 0,0,16'h0000,0,0,0,  1,16'h0005,0,16'h0000,16'h0000,0);
    tv[5]  = mk(0,0,0,0, 0,0,16'h0000,1,3,0,  0,16'h0005,1,16'h0005,16'h0000,0);
    tv[6]  = mk(0,1,0,0, 3,0,16'h7FF0,0,0,0,  0,16'h0005,0,16'h0005,16'h0000,1);
    tv[7]  = mk(0,1,1,0, 3,1,16'h0020,0,0,0,  0,16'h0005,0,16'h0005,16'h0000,1);
    tv[8]  = mk(0,0,0,0, 0,0,16'h0000,0,0,0,  1,16'h7FFF,0,16'h0005,16'hFFFF,0);
    tv[9]  = mk(0,0,0,0, 0,0,16'h0000,0,0,1,  0,16'h7FFF,0,16'h0005,16'h0000,0);
    tv[10] = mk(0,1,0,1, 3,2,16'hFFF0,0,0,0,  0,16'h7FFF,0,16'h0005,16'h0000,1);
    tv[11] = mk(0,0,0,0, 0,0,16'h0000,0,0,0,  1,16'h0000,0,16'h0005,16'h0000,0);
    tv[12] = mk(0,0,0,0, 0,0,16'h0000,1,3,0,  0,16'h0000,1,16'h7FFF,16'h0000,0);
    tv[13] = mk(0,1,1,0, 5,1,16'h0001,0,0,0,  0,16'h0000,0,16'h7FFF,16'h0000,1);
    tv[14] = mk(0,1,1,0, 5,1,16'h0001,0,0,0,  1,16'h0001,0,16'h7FFF,16'h0000,1);
    tv[15] = mk(0,1,1,0, 5,1,16'h0001,0,0,0,  1,16'h0002,0,16'h7FFF,16'h0000,1);
    tv[16] = mk(0,0,0,0, 0,0,16'h0000,0,0,0,  1,16'h0003,0,16'h7FFF,16'h0000,0);
    tv[17] = mk(0,1,1,0, 3,2,16'h0001,0,0,0,  0,16'h0003,0,16'h7FFF,16'h0000,1);
    tv[18] = mk(0,0,0,0, 0,0,16'h0000,0,0,1,  1,16'h7FFF,0,16'h7FFF,16'hFFFF,0);
    tv[19] = mk(0,0,0,0, 0,0,16'h0000,0,0,1,  0,16'h7FFF,0,16'h7FFF,16'h0000,0);
    tv[20] = mk(0,1,0,0, 9,0,16'h1234,0,0,0,  0,16'h7FFF,0,16'h7FFF,16'h0000,1);
    tv[21] = mk(0,0,0,0, 0,0,16'h0000,1,9,0,  0,16'h7FFF,1,16'h1234,16'h0000,0);
    tv[22] = mk(0,1,1,0, 9,3,16'h7FFF,0,0,0,  0,16'h7FFF,0,16'h1234,16'h0000,1);
    tv[23] = mk(0,0,0,0, 0,0,16'h0000,1,9,0,  0,16'h7FFF,1,16'h0000,16'h0000,0);
    tv[24] = mk(0,1,0,0,12,1,16'h0042,0,0,0,  0,16'h7FFF,0,16'h0000,16'h0000,1);
    tv[25] = mk(1,0,0,0, 0,0,16'h0000,0,0,0,  0,16'h0000,0,16'h0000,16'h0000,0);
    tv[26] = mk(0,0,0,0, 0,0,16'h0000,1,12,0, 0,16'h0000,1,16'h0000,16'h0000,0);
    tv[27] = mk(0,0,0,0, 0,0,16'h0000,0,0,0,  0,16'h0000,0,16'h0000,16'h0000,0);
    for (int i = 0; i < NV; i++) begin
      rst = tv[i].rst; i_data_v = tv[i].dv; i_en_vadd = tv[i].va; i_en_relu = tv[i].rl;
      i_rf_idx = tv[i].idx; i_rf_mux = tv[i].mux; i_data = {16{tv[i].d}};
      i_rd_en = tv[i].rd; i_rd_idx = tv[i].ridx; i_sat_clr = tv[i].clr;
      cyc();
      chk($sformatf("v%0d o_data_v", i), 256'(o_data_v), 256'(tv[i].edv));
      chk($sformatf("v%0d o_data", i), o_data, {16{tv[i].edl}});
      chk($sformatf("v%0d o_rd_v", i), 256'(o_rd_v), 256'(tv[i].erv));
      chk($sformatf("v%0d o_rd_data", i), o_rd_data, {16{tv[i].erl}});
      chk($sformatf("v%0d o_sat", i), 256'(o_sat), 256'(tv[i].esat));
      chk($sformatf("v%0d o_busy", i), 256'(o_busy), 256'(tv[i].ebusy));
    end
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      i_data_v = ($urandom_range(0, 3) != 0);
      i_en_vadd = 1'($urandom);
      i_en_relu = 1'($urandom);
      i_rf_idx = 5'($urandom_range(0, 3));
      i_rf_mux = 2'($urandom);
      i_data = rand_vec();
      i_rd_en = 1'($urandom);
      i_rd_idx = 5'($urandom_range(0, 3));
      i_sat_clr = ($urandom_range(0, 15) == 0);
      cyc();
      chk_model($sformatf("r%0d", n));
    end
    rst = 1'b0; i_data_v = 1'b0; i_sat_clr = 1'b0;
    for (int n = 0; n < 32; n++) begin
      i_rd_en = 1'b1;
      i_rd_idx = 5'(n);
      cyc();
      chk_model($sformatf("drain%0d", n));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
